mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory interface.
- Accepts one word read or write request from the control unit/datapath, inserts a configurable number of wait states, then returns read data with a one-cycle Ack pulse.
- Holds the word-addressed storage array and sits between the datapath address/data muxes and the instruction/data memory space.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 4.
- WAIT_STATES, 1, extra cycles between request acceptance and Ack; range 0..15.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  request strobe; sampled only when the block can accept.
- Wr  in  1  1 = write, 0 = read; qualified by Req.
- Address  in  32  byte address.
- WriteData  in  32  write data; qualified by Req & Wr.
- ReadData  out  32  read result; valid when Ack = 1 and held until the next read completes.
- Ack  out  1  one-cycle completion pulse, for reads and writes.
- Busy  out  1  high while a request is in flight (WAIT or RESP state).
- Err  out  1  access-error flag; see Optional Feature.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - State goes to IDLE.
  - ReadData = 0, Ack = 0, Busy = 0, Err = 0.
  - Wait counter = 0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- Accept rule: Req is accepted at a rising edge when the state is IDLE, or RESP (back-to-back).
  - On accept, latch Address, Wr and WriteData into internal registers.
  - Later changes on the inputs have no effect on the latched request.
- Transitions:
  - IDLE with Req: go to WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1), else go to RESP.
  - IDLE without Req: stay in IDLE.
  - WAIT: decrement the counter each cycle; when the counter = 0, go to RESP.
  - RESP: Ack = 1 for exactly this cycle. Then go to IDLE, or accept a new Req (same rule as IDLE).
- Latency: Ack is high in cycle N+1+WAIT_STATES, where N is the acceptance edge. Minimum request spacing is 1+WAIT_STATES cycles.
- Write:
  - The storage write happens at the edge that enters RESP.
  - A read of the same word accepted afterwards returns the new data.
- Read:
  - ReadData is registered at the edge that enters RESP, from the latched word index.
  - ReadData is unchanged by writes.
- Word index = latched Address[log2(DEPTH_WORDS)+1:2].
  - Without the optional feature, Address[1:0] and the bits above the index are ignored, so the address space wraps modulo DEPTH_WORDS*4.
- Busy is 1 in WAIT and RESP. It stays 1 through a back-to-back acceptance.
- Req while in WAIT: ignored, not queued. The requester must wait for Ack.
- Reset asserted mid-request: the request is dropped, a pending write is not performed, and no Ack is issued.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- When defined, a latched request is in error if Address[1:0] != 0 or Address >= DEPTH_WORDS*4. For an errored request:
  - the write is suppressed;
  - ReadData is driven to 0;
  - Err = 1 in the same cycle as Ack, otherwise 0;
  - timing is identical to a normal access.
- When not defined, Err is tied to 0 and the wrap/ignore rules above apply.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - WORD_BYTES = 4;
  - WAIT_CNT_W = 4;
  - index-width function clog2(DEPTH_WORDS).
- Sub-module mem_array:
  - single-port storage, DEPTH_WORDS x 32;
  - synchronous write enable and registered read;
  - instantiated once.
- mem_responder holds the FSM, the wait counter, the request latch and the error check.

Test Plan:
- WAIT_STATES = 1: write 0xDEADBEEF at 0x10, then read 0x10. Ack is high 2 cycles after each accept, and ReadData = 0xDEADBEEF on the read Ack.
- WAIT_STATES = 0: back-to-back reads of 0x0 and 0x4, with Req held high. Ack is high on 2 consecutive cycles, Busy stays 1, and the data matches the preloaded words.
- DEPTH_WORDS = 256: write 0x12345678 to 0x400, then read 0x0. Without the macro, 0x12345678 is returned (wrap). With MEM_RANGE_CHECK_EN, the write is suppressed and Err = 1 on its Ack.
- MEM_RANGE_CHECK_EN: read 0x6 (misaligned). Ack arrives with ReadData = 0 and Err = 1; the next aligned read has Err = 0.
- WAIT_STATES = 3: pulse Reset low 2 cycles after a write to 0x20 (0xCAFEF00D) is accepted. No Ack, all outputs 0, and a later read of 0x20 returns the old value.
- Req pulsed during WAIT: ignored. Exactly one Ack is produced and Busy drops to 0 the cycle after Ack.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared state encoding, sizing constants and index-width helper for mem_responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// mem_array: single-port DEPTH_WORDS x 32 storage, synchronous write, registered read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] storage [DEPTH_WORDS];

  // Storage contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) storage[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= clr ? '0 : storage[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// mem_responder: word memory responder with WAIT_STATES wait cycles and a one-cycle Ack.
// Build option MEM_RANGE_CHECK_EN flags misaligned or out-of-range accesses on Err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Busy,
  output logic        Err
);

  localparam int AW      = clog2(DEPTH_WORDS);
  localparam int LSB     = clog2(WORD_BYTES);
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
    WAIT_CNT_W'(NO_WAIT ? 0 : WAIT_STATES - 1);

  state_t                state;
  state_t                state_nx;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic                  accept;
  logic                  enter_resp;
  logic                  in_err;
  logic [AW-1:0]         in_idx;

  logic                  lat_wr;
  logic                  lat_err;
  logic [AW-1:0]         lat_idx;
  logic [31:0]           lat_wdata;

  logic                  op_wr;
  logic                  op_err;
  logic [AW-1:0]         op_idx;
  logic [31:0]           op_wdata;
  logic                  mem_we;
  logic                  mem_re;

  assign in_idx = Address[AW+LSB-1:LSB];

`ifdef MEM_RANGE_CHECK_EN
  assign in_err = (Address[LSB-1:0] != '0) || (Address[31:AW+LSB] != '0);
`else
  logic unused_addr_bits;
  assign in_err           = 1'b0;
  assign unused_addr_bits = ^{Address[31:AW+LSB], Address[LSB-1:0]};
`endif

  assign accept     = Req && ((state == IDLE) || (state == RESP));
  assign enter_resp = accept ? NO_WAIT : ((state == WAIT) && (wait_cnt == '0));

  // With no wait states the access happens on the accept edge itself,
  // before the latch has captured the request, so use the live inputs.
  assign op_wr    = NO_WAIT ? Wr        : lat_wr;
  assign op_err   = NO_WAIT ? in_err    : lat_err;
  assign op_idx   = NO_WAIT ? in_idx    : lat_idx;
  assign op_wdata = NO_WAIT ? WriteData : lat_wdata;

  assign mem_we = enter_resp && op_wr && !op_err;
  assign mem_re = enter_resp && (!op_wr || op_err);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_wr    <= Wr;
      lat_err   <= in_err;
      lat_idx   <= in_idx;
      lat_wdata <= WriteData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= CNT_LOAD;
    end else if ((state == WAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = NO_WAIT ? RESP : WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = RESP;
      RESP:    state_nx = accept ? (NO_WAIT ? RESP : WAIT) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Ack  = 1'b0;
    Busy = 1'b0;
    Err  = 1'b0;
    unique case (state)
      IDLE: ;
      WAIT: Busy = 1'b1;
      RESP: begin
        Ack  = 1'b1;
        Busy = 1'b1;
        Err  = lat_err;
      end
      default: ;
    endcase
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk  (Clk),
    .rst_n(Reset),
    .we   (mem_we),
    .re   (mem_re),
    .clr  (op_err),
    .addr (op_idx),
    .wdata(op_wdata),
    .rdata(ReadData)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mem_responder: three responders (WAIT_STATES 1, 0, 3) checked by a queue-based scoreboard.
module tb_mem_responder;

  localparam int N = 3;
  localparam int K_BUSY  = 0;
  localparam int K_ACK   = 1;
  localparam int K_ERR   = 2;
  localparam int K_RDATA = 3;
  localparam int K_DRAIN = 4;
`ifdef MEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n [N];
  logic        req   [N];
  logic        wr    [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ack   [N];
  logic        busy  [N];
  logic        err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .Clk      (clk),
      .Reset    (rst_n[g]),
      .Req      (req[g]),
      .Wr       (wr[g]),
      .Address  (addr[g]),
      .WriteData(wdata[g]),
      .ReadData (rdata[g]),
      .Ack      (ack[g]),
      .Busy     (busy[g]),
      .Err      (err[g])
    );
  end

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          at;
  } exp_t;

  typedef struct {
    int          at;
    int          id;
    int          kind;
    logic [31:0] val;
  } st_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  st_t  sq[$];
  logic [31:0] last_rd [N];
  int checks = 0;
  int errors = 0;

  function automatic int ws_of(input int id);
    return (id == 0) ? 1 : ((id == 1) ? 0 : 3);
  endfunction

  function automatic void qpush(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void check(input string name, input int id,
                                input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h (cycle %0d)", name, id, act, exp, cyc);
    end
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_BUSY:  return "busy";
      K_ACK:   return "ack";
      K_ERR:   return "err";
      K_RDATA: return "rdata";
      default: return "drain";
    endcase
  endfunction

  // Monitor: pops the expected response whenever a DUT presents Ack, then
  // applies any status expectations scheduled for this cycle.
  always @(negedge clk) begin
    st_t         s;
    logic [31:0] act;
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack[%0d]: got Ack=1, expected no Ack (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = qpop(i);
          check("ack_rdata", i, rdata[i], e.rd);
          check("ack_err", i, {31'd0, err[i]}, {31'd0, e.er});
          check("ack_cycle", i, cyc, e.at);
        end
      end
    end
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      s = sq.pop_front();
      case (s.kind)
        K_BUSY:  act = {31'd0, busy[s.id]};
        K_ACK:   act = {31'd0, ack[s.id]};
        K_ERR:   act = {31'd0, err[s.id]};
        K_RDATA: act = rdata[s.id];
        default: act = 32'(q0.size() + q1.size() + q2.size());
      endcase
      check(kname(s.kind), s.id, act, s.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input int id, input int kind, input logic [31:0] val, input int at);
    st_t s;
    s.at = at; s.id = id; s.kind = kind; s.val = val;
    sq.push_back(s);
  endtask

  // Drive one request for a cycle; push its expected Ack if push is set.
  task automatic issue(input int id, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input bit push);
    exp_t e;
    req[id] = 1'b1; wr[id] = w; addr[id] = a; wdata[id] = d;
    if (push) begin
      if (exp_err)  e.rd = 32'd0;
      else if (w)   e.rd = last_rd[id];
      else          e.rd = exp_rd;
      e.er = exp_err;
      e.at = cyc + 1 + ws_of(id);
      last_rd[id] = e.rd;
      qpush(id, e);
    end
    tick();
    req[id] = 1'b0; wr[id] = ~w; addr[id] = 32'hFFFF_FFFC; wdata[id] = 32'h5555_AAAA;
  endtask

  task automatic settle(input int id);
    repeat (ws_of(id) + 1) tick();
  endtask

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      want(i, K_BUSY, 0, cyc); want(i, K_ACK, 0, cyc);
      want(i, K_ERR, 0, cyc);  want(i, K_RDATA, 0, cyc);
    end
    tick();
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    repeat (2) tick();

    // WAIT_STATES = 1: preload, write/read, wrap and misalignment.
    issue(0, 1, 32'h0,   32'hA5A5_A5A5, 0, 0, 1); settle(0);
    issue(0, 1, 32'h4,   32'h0BAD_F00D, 0, 0, 1); settle(0);
    issue(0, 1, 32'h10,  32'hDEAD_BEEF, 0, 0, 1); settle(0);
    issue(0, 0, 32'h10,  0, 32'hDEAD_BEEF, 0, 1); settle(0);
    issue(0, 0, 32'h0,   0, 32'hA5A5_A5A5, 0, 1); settle(0);
    issue(0, 1, 32'h400, 32'h1234_5678, 0, RC, 1); settle(0);
    issue(0, 0, 32'h0,   0, RC ? 32'hA5A5_A5A5 : 32'h1234_5678, 0, 1); settle(0);
    issue(0, 0, 32'h6,   0, RC ? 32'h0 : 32'h0BAD_F00D, RC, 1); settle(0);
    issue(0, 0, 32'h4,   0, 32'h0BAD_F00D, 0, 1); settle(0);

    // WAIT_STATES = 0: back-to-back with Req held high.
    issue(1, 1, 32'h0, 32'h1111_2222, 0, 0, 1);
    issue(1, 1, 32'h4, 32'h3333_4444, 0, 0, 1); settle(1);
    base = cyc;
    want(1, K_BUSY, 1, base + 1); want(1, K_BUSY, 1, base + 2); want(1, K_BUSY, 0, base + 3);
    issue(1, 0, 32'h0, 0, 32'h1111_2222, 0, 1);
    issue(1, 0, 32'h4, 0, 32'h3333_4444, 0, 1); settle(1);

    // WAIT_STATES = 3: reset in the middle of a write.
    issue(2, 1, 32'h20, 32'h1111_1111, 0, 0, 1); settle(2);
    issue(2, 0, 32'h20, 0, 32'h1111_1111, 0, 1); settle(2);
    base = cyc;
    issue(2, 1, 32'h20, 32'hCAFE_F00D, 0, 0, 0);
    tick();
    rst_n[2] = 1'b0;
    last_rd[2] = '0;
    want(2, K_BUSY, 0, base + 2); want(2, K_ACK, 0, base + 2);
    want(2, K_ERR, 0, base + 2);  want(2, K_RDATA, 0, base + 2);
    tick();
    want(2, K_BUSY, 0, base + 3);
    tick();
    want(2, K_BUSY, 0, base + 4); want(2, K_ACK, 0, base + 4);
    rst_n[2] = 1'b1;
    repeat (2) tick();
    issue(2, 0, 32'h20, 0, 32'h1111_1111, 0, 1); settle(2);

    // Req pulsed while in WAIT must be ignored.
    base = cyc;
    issue(2, 0, 32'h20, 0, 32'h1111_1111, 0, 1);
    tick();
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hBAD0_BAD0;
    tick();
    req[2] = 1'b0;
    want(2, K_BUSY, 1, base + 4); want(2, K_BUSY, 0, base + 5);
    repeat (4) tick();
    issue(2, 0, 32'h20, 0, 32'h1111_1111, 0, 1); settle(2);

    for (int k = 0; k < 64 && (q0.size() + q1.size() + q2.size()) != 0; k++) tick();
    want(0, K_DRAIN, 0, cyc);
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
